pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter ADDR_W, default 32, width of every address port.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 Parameter STEP, default 4, sequential increment in bytes.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-005 i_clk  in  1  single clock; all state on rising edge.
REQ-006 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 i_pc_write  in  1  1 = PC may advance; 0 = hazard stall.
REQ-008 i_flush_vld  in  1  trap/exception redirect request.
REQ-009 i_flush_pc  in  ADDR_W  trap target.
REQ-010 i_br_taken  in  1  resolved taken branch/jump.
REQ-011 i_br_target  in  ADDR_W  branch/jump target.
REQ-012 i_call  in  1  current fetch is a call; push return address.
REQ-013 i_ret  in  1  current fetch is a return; predict from RAS.
REQ-014 o_pc  out  ADDR_W  current fetch PC, registered.
REQ-015 o_pc_plus  out  ADDR_W  o_pc + STEP, combinational from o_pc.
REQ-016 o_redirect  out  1  registered; 1 for one cycle after a flush or branch load.
REQ-017 o_ras_empty / o_ras_full  out  1 each  RAS occupancy flags, registered state.

Function
REQ-018 Next-PC priority SHALL be: flush > branch > RAS return > sequential > hold.
REQ-019 i_flush_vld=1 SHALL load i_flush_pc next edge regardless of i_pc_write, i_br_taken, i_call, i_ret.
REQ-020 i_br_taken=1 (no flush) SHALL load i_br_target next edge regardless of i_pc_write.
REQ-021 With no flush/branch and i_pc_write=0, o_pc and RAS SHALL hold; i_call/i_ret ignored.
REQ-022 With no flush/branch and i_pc_write=1: i_ret with RAS non-empty -> load RAS top; otherwise load o_pc+STEP.
REQ-023 Arithmetic SHALL wrap modulo 2^ADDR_W (max address + STEP -> low address, no flag).
REQ-024 RAS updates SHALL occur only on cycles of REQ-022 (advancing, no flush/branch).
REQ-025 Push (i_call only): write o_pc+STEP at top; count +1; when full, overwrite oldest circularly, count stays RAS_DEPTH.
REQ-026 Pop (i_ret only): count -1; when empty, no pop, PC goes sequential, count stays 0.
REQ-027 i_call and i_ret together: PC loads current top (if non-empty), then top is replaced by o_pc+STEP; count unchanged (empty: push only, PC sequential).
REQ-028 Flush and branch SHALL NOT modify RAS contents or count.
REQ-029 o_redirect SHALL be 1 in the cycle following any edge where REQ-019 or REQ-020 applied, else 0.
REQ-030 Latency: every input affects o_pc exactly one edge later; no combinational input-to-o_pc path.

Reset
REQ-031 i_rst_n low SHALL immediately force o_pc=RESET_VEC, o_redirect=0, RAS count=0, o_ras_empty=1, o_ras_full=0, independent of i_clk.
REQ-032 RAS entry contents need not be reset; they are unobservable while count=0.
REQ-033 Reset asserted mid-operation (stall, pending branch, full RAS) SHALL discard all state; first edge after release applies REQ-018 from RESET_VEC.

Structure
REQ-034 Shared package SHALL hold next-PC select encoding (FLUSH, BRANCH, RAS, SEQ, HOLD) and default ADDR_W/STEP constants.
REQ-035 RAS SHALL be a separate sub-module pc_ras (push/pop/replace, top, empty, full); pc_unit holds PC register and priority mux.

Verification
REQ-036 Reset release, i_pc_write=1, 3 edges -> o_pc 0x0,0x4,0x8,0xC; o_redirect 0.
REQ-037 At o_pc=0x10, i_pc_write=0 and i_br_taken=1, target 0x200 -> o_pc=0x200, o_redirect=1 one cycle; stall-only cycle afterwards holds 0x200.
REQ-038 Same edge i_flush_vld=1 (0x8000_0000) and i_br_taken=1 (0x40) -> o_pc=0x8000_0000; RAS unchanged.
REQ-039 RAS_DEPTH=4: five calls at 0x100,0x200,0x300,0x400,0x500 then five returns -> PC 0x504,0x404,0x304,0x204, then sequential; o_ras_full after 4th call, o_ras_empty after 4th return.
REQ-040 o_pc=0xFFFF_FFFC, advance -> o_pc=0x0000_0000; i_ret on empty RAS -> sequential, count 0.
REQ-041 Assert i_rst_n low between edges with RAS count 3 -> o_pc=RESET_VEC immediately, o_ras_empty=1, no clock required.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the fetch PC unit: next-PC source encoding and
// default geometry constants.
package pc_unit_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_STEP   = 4;

  // Next-PC source, listed in priority order (highest first).
  typedef enum logic [2:0] {
    SEL_FLUSH  = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_RAS    = 3'd2,
    SEL_SEQ    = 3'd3,
    SEL_HOLD   = 3'd4
  } npc_sel_e;

endpackage

// File: rtl/pc_unit_ras.sv
// Return-address stack: circular buffer that overwrites its oldest entry
// when full. Push+pop together replaces the top in place.
module pc_ras #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_wdata,
  output logic [ADDR_W-1:0] o_top,
  output logic              o_empty,
  output logic              o_full
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [IW-1:0]     r_top_idx;
  logic [CW-1:0]     r_cnt;

  logic          w_empty;
  logic          w_do_push;
  logic          w_do_pop;
  logic          w_do_repl;
  logic [IW-1:0] w_push_idx;

  // Decode the requested operation against current occupancy.
  always_comb begin
    w_empty    = (r_cnt == '0);
    // A combined call+return on an empty stack degenerates to a plain push.
    w_do_push  = i_push && (!i_pop || w_empty);
    w_do_pop   = i_pop && !i_push && !w_empty;
    w_do_repl  = i_push && i_pop && !w_empty;
    w_push_idx = r_top_idx + IW'(1);
  end

  // Top pointer and occupancy count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_top_idx <= '0;
      r_cnt     <= '0;
    end else if (w_do_push) begin
      r_top_idx <= w_push_idx;
      if (r_cnt != CW'(DEPTH)) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else if (w_do_pop) begin
      r_top_idx <= r_top_idx - IW'(1);
      r_cnt     <= r_cnt - CW'(1);
    end
  end

  // Entry storage; contents are meaningless while the count is zero, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[w_push_idx] <= i_wdata;
    end else if (w_do_repl) begin
      r_mem[r_top_idx] <= i_wdata;
    end
  end

  assign o_top   = r_mem[r_top_idx];
  assign o_empty = w_empty;
  assign o_full  = (r_cnt == CW'(DEPTH));

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with flush/branch redirect, hazard stall and
// return-address-stack prediction.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                STEP      = DEF_STEP,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pc_write,
  input  logic              i_flush_vld,
  input  logic [ADDR_W-1:0] i_flush_pc,
  input  logic              i_br_taken,
  input  logic [ADDR_W-1:0] i_br_target,
  input  logic              i_call,
  input  logic              i_ret,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus,
  output logic              o_redirect,
  output logic              o_ras_empty,
  output logic              o_ras_full
);

  localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

  logic [ADDR_W-1:0] r_pc;
  logic              r_redirect;

  npc_sel_e          w_sel;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_pc_plus;
  logic              w_adv;
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_ras_empty;
  logic              w_ras_full;

  assign w_pc_plus = r_pc + STEP_W;
  // The stack only moves on cycles that advance sequentially.
  assign w_adv     = i_pc_write && !i_flush_vld && !i_br_taken;

  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_adv && i_call),
    .i_pop   (w_adv && i_ret),
    .i_wdata (w_pc_plus),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty),
    .o_full  (w_ras_full)
  );

  // Select the next-PC source by priority.
  always_comb begin
    w_sel = SEL_HOLD;
    if (i_flush_vld) begin
      w_sel = SEL_FLUSH;
    end else if (i_br_taken) begin
      w_sel = SEL_BRANCH;
    end else if (i_pc_write) begin
      w_sel = (i_ret && !w_ras_empty) ? SEL_RAS : SEL_SEQ;
    end
  end

  // Next-PC mux.
  always_comb begin
    w_pc_next = r_pc;
    unique case (w_sel)
      SEL_FLUSH:  w_pc_next = i_flush_pc;
      SEL_BRANCH: w_pc_next = i_br_target;
      SEL_RAS:    w_pc_next = w_ras_top;
      SEL_SEQ:    w_pc_next = w_pc_plus;
      default:    w_pc_next = r_pc;
    endcase
  end

  // PC register and one-cycle redirect indication.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc       <= RESET_VEC;
      r_redirect <= 1'b0;
    end else begin
      r_pc       <= w_pc_next;
      r_redirect <= (w_sel == SEL_FLUSH) || (w_sel == SEL_BRANCH);
    end
  end

  assign o_pc        = r_pc;
  assign o_pc_plus   = w_pc_plus;
  assign o_redirect  = r_redirect;
  assign o_ras_empty = w_ras_empty;
  assign o_ras_full  = w_ras_full;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit with a queue-based reference model.
module tb_pc_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        pc_write;
  logic        flush_vld;
  logic [31:0] flush_pc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        call;
  logic        ret;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic        redirect;
  logic        ras_empty;
  logic        ras_full;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_redir;
  logic [31:0] m_ras [$];

  pc_unit #(
    .ADDR_W    (32),
    .RESET_VEC (32'h0000_0000),
    .STEP      (4),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_pc_write  (pc_write),
    .i_flush_vld (flush_vld),
    .i_flush_pc  (flush_pc),
    .i_br_taken  (br_taken),
    .i_br_target (br_target),
    .i_call      (call),
    .i_ret       (ret),
    .o_pc        (pc),
    .o_pc_plus   (pc_plus),
    .o_redirect  (redirect),
    .o_ras_empty (ras_empty),
    .o_ras_full  (ras_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc    = 32'h0;
    m_redir = 1'b0;
    m_ras.delete();
  endtask

  // Behavioural next state from the architectural rules.
  task automatic model_step(input logic wr, input logic fl, input logic [31:0] fpc,
                            input logic br, input logic [31:0] bt,
                            input logic cl, input logic rt);
    logic [31:0] nxt;
    nxt = m_pc + 32'd4;
    if (fl) begin
      m_pc = fpc; m_redir = 1'b1;
    end else if (br) begin
      m_pc = bt; m_redir = 1'b1;
    end else begin
      m_redir = 1'b0;
      if (wr) begin
        if (cl && rt && m_ras.size() > 0) begin
          m_pc = m_ras[m_ras.size()-1];
          m_ras[m_ras.size()-1] = nxt;
        end else if (rt && !cl && m_ras.size() > 0) begin
          m_pc = m_ras.pop_back();
        end else begin
          if (cl) begin
            m_ras.push_back(nxt);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
          end
          m_pc = nxt;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, update the model, and advance past the edge.
  task automatic cycle(input logic wr, input logic fl, input logic [31:0] fpc,
                       input logic br, input logic [31:0] bt,
                       input logic cl, input logic rt);
    pc_write = wr; flush_vld = fl; flush_pc = fpc;
    br_taken = br; br_target = bt; call = cl; ret = rt;
    model_step(wr, fl, fpc, br, bt, cl, rt);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pc_write = 0; flush_vld = 0; flush_pc = 0; br_taken = 0; br_target = 0; call = 0; ret = 0;
    model_reset();
    #3;
    n_total++;
    if ({pc, redirect, ras_empty, ras_full} !== {32'h0, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_state: got pc=%h redir=%b empty=%b full=%b want pc=0 redir=0 empty=1 full=0",
               pc, redirect, ras_empty, ras_full);
    else n_pass++;
    #5 rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    n_total++;
    if (pc !== 32'h0) $display("FAIL seq_start: got %h want 00000000", pc);
    else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      cycle(1, 0, 0, 0, 0, 0, 0);
      n_total++;
      if (pc !== 32'(i * 4) || redirect !== 1'b0)
        $display("FAIL seq_step%0d: got pc=%h redir=%b want pc=%h redir=0", i, pc, redirect, 32'(i * 4));
      else n_pass++;
    end
  endtask

  task automatic test_branch_stall();
    cycle(1, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (pc !== 32'h10) $display("FAIL br_pre: got %h want 00000010", pc);
    else n_pass++;
    cycle(0, 0, 0, 1, 32'h200, 0, 0);
    n_total++;
    if (pc !== 32'h200 || redirect !== 1'b1)
      $display("FAIL br_load: got pc=%h redir=%b want pc=00000200 redir=1", pc, redirect);
    else n_pass++;
    cycle(0, 0, 0, 0, 0, 1, 1);
    n_total++;
    if (pc !== 32'h200 || redirect !== 1'b0 || ras_empty !== 1'b1)
      $display("FAIL stall_hold: got pc=%h redir=%b empty=%b want pc=00000200 redir=0 empty=1",
               pc, redirect, ras_empty);
    else n_pass++;
  endtask

  task automatic test_flush_priority();
    cycle(1, 0, 0, 0, 0, 1, 0);
    n_total++;
    if (pc !== 32'h204 || ras_empty !== 1'b0)
      $display("FAIL call_push: got pc=%h empty=%b want pc=00000204 empty=0", pc, ras_empty);
    else n_pass++;
    cycle(1, 1, 32'h8000_0000, 1, 32'h40, 1, 0);
    n_total++;
    if (pc !== 32'h8000_0000 || redirect !== 1'b1 || ras_empty !== 1'b0)
      $display("FAIL flush_over_br: got pc=%h redir=%b empty=%b want pc=80000000 redir=1 empty=0",
               pc, redirect, ras_empty);
    else n_pass++;
    cycle(1, 0, 0, 0, 0, 0, 1);
    n_total++;
    if (pc !== 32'h204 || ras_empty !== 1'b1 || redirect !== 1'b0)
      $display("FAIL ras_intact: got pc=%h empty=%b redir=%b want pc=00000204 empty=1 redir=0",
               pc, ras_empty, redirect);
    else n_pass++;
  endtask

  task automatic test_ras_overflow();
    for (int i = 1; i <= 5; i++) begin
      cycle(1, 0, 0, 1, 32'(i * 32'h100), 0, 0);
      cycle(1, 0, 0, 0, 0, 1, 0);
      n_total++;
      if (pc !== 32'(i * 32'h100 + 4) || ras_full !== (i >= 4) || ras_empty !== 1'b0)
        $display("FAIL call%0d: got pc=%h full=%b empty=%b want pc=%h full=%b empty=0",
                 i, pc, ras_full, ras_empty, 32'(i * 32'h100 + 4), (i >= 4));
      else n_pass++;
    end
    for (int i = 1; i <= 4; i++) begin
      cycle(1, 0, 0, 0, 0, 0, 1);
      n_total++;
      if (pc !== 32'((6 - i) * 32'h100 + 4) || ras_empty !== (i == 4) || ras_full !== 1'b0)
        $display("FAIL ret%0d: got pc=%h empty=%b full=%b want pc=%h empty=%b full=0",
                 i, pc, ras_empty, ras_full, 32'((6 - i) * 32'h100 + 4), (i == 4));
      else n_pass++;
    end
    cycle(1, 0, 0, 0, 0, 0, 1);
    n_total++;
    if (pc !== 32'h208 || ras_empty !== 1'b1)
      $display("FAIL ret5_seq: got pc=%h empty=%b want pc=00000208 empty=1", pc, ras_empty);
    else n_pass++;
  endtask

  task automatic test_wrap();
    cycle(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    n_total++;
    if (pc_plus !== 32'h0) $display("FAIL pc_plus_wrap: got %h want 00000000", pc_plus);
    else n_pass++;
    cycle(1, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (pc !== 32'h0 || redirect !== 1'b0) $display("FAIL pc_wrap: got pc=%h redir=%b want 00000000 0", pc, redirect);
    else n_pass++;
    cycle(1, 0, 0, 0, 0, 0, 1);
    n_total++;
    if (pc !== 32'h4 || ras_empty !== 1'b1)
      $display("FAIL ret_empty: got pc=%h empty=%b want pc=00000004 empty=1", pc, ras_empty);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 1, 0);
    n_total++;
    if (ras_empty !== 1'b0 || ras_full !== 1'b0 || pc !== 32'h10)
      $display("FAIL pre_reset: got pc=%h empty=%b full=%b want pc=00000010 empty=0 full=0",
               pc, ras_empty, ras_full);
    else n_pass++;
    pc_write = 0; br_taken = 1; br_target = 32'h300;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_total++;
    if ({pc, redirect, ras_empty, ras_full} !== {32'h0, 1'b0, 1'b1, 1'b0})
      $display("FAIL async_reset: got pc=%h redir=%b empty=%b full=%b want pc=0 redir=0 empty=1 full=0",
               pc, redirect, ras_empty, ras_full);
    else n_pass++;
    br_taken = 0; br_target = 0;
    #1 rst_n = 1'b1;
    cycle(1, 0, 0, 0, 0, 0, 1);
    n_total++;
    if (pc !== 32'h4 || ras_empty !== 1'b1 || redirect !== 1'b0)
      $display("FAIL post_reset: got pc=%h empty=%b redir=%b want pc=00000004 empty=1 redir=0",
               pc, ras_empty, redirect);
    else n_pass++;
  endtask

  task automatic test_random();
    logic wr, fl, br, cl, rt;
    logic [31:0] fpc, bt;
    for (int i = 0; i < 400; i++) begin
      wr  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      br  = ($urandom_range(0, 7) == 0);
      cl  = ($urandom_range(0, 3) == 0);
      rt  = ($urandom_range(0, 3) == 0);
      fpc = $urandom() & 32'hFFFF_FFFC;
      bt  = $urandom() & 32'hFFFF_FFFC;
      cycle(wr, fl, fpc, br, bt, cl, rt);
      n_total++;
      if ({pc, pc_plus, redirect, ras_empty, ras_full} !==
          {m_pc, m_pc + 32'd4, m_redir, (m_ras.size() == 0), (m_ras.size() == DEPTH)})
        $display("FAIL random%0d: got pc=%h plus=%h redir=%b empty=%b full=%b want pc=%h plus=%h redir=%b empty=%b full=%b",
                 i, pc, pc_plus, redirect, ras_empty, ras_full,
                 m_pc, m_pc + 32'd4, m_redir, (m_ras.size() == 0), (m_ras.size() == DEPTH));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_stall();
    test_flush_priority();
    test_ras_overflow();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
